// File: rtl/multicycle_main_control.sv
// Main control FSM for a multicycle MIPS datapath (Moore style).
// Sequences fetch/decode/execute/memory/writeback and drives every datapath select/enable.
// Ports: clk/rst_n (async active-low); opcode (IR[31:26]); mem_ready (memory handshake);
//        datapath controls (pc_write .. pc_source); state (debug); illegal_op (sticky);
//        instr_count (retired instructions, wraps modulo 2^CNT_W).
module multicycle_main_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE   = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EX   = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [3:0] cur_state;
  logic [3:0] nxt_state;
  logic       retire;
  logic       bad_opcode;

  assign state = cur_state;

  // State register, sticky illegal flag and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state   <= S_FETCH;
      illegal_op  <= 1'b0;
      instr_count <= '0;
    end else begin
      cur_state <= nxt_state;
      if (bad_opcode) begin
        illegal_op <= 1'b1;
      end
      if (retire) begin
        instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Next-state logic; retire marks the edge leaving an instruction's last state.
  always_comb begin
    nxt_state  = S_FETCH;
    retire     = 1'b0;
    bad_opcode = 1'b0;
    case (cur_state)
      S_FETCH:    nxt_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      nxt_state = S_EXECUTE;
          OP_LW, OP_SW:  nxt_state = S_MEM_ADDR;
          OP_BEQ:        nxt_state = S_BRANCH;
          OP_J:          nxt_state = S_JUMP;
          OP_ADDI:       nxt_state = S_ADDI_EX;
          default: begin
            nxt_state  = S_FETCH;
            bad_opcode = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: nxt_state = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: nxt_state = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: begin
        nxt_state = mem_ready ? S_FETCH : S_MEM_WRITE;
        retire    = mem_ready;
      end
      S_EXECUTE:  nxt_state = S_R_WB;
      S_ADDI_EX:  nxt_state = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
        nxt_state = S_FETCH;
        retire    = 1'b1;
      end
      default:    nxt_state = S_FETCH;  // unused codes recover to FETCH
    endcase
  end

  // Output decode from the state register (FETCH also looks at mem_ready).
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (cur_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR and PC only update on the cycle the fetch actually completes.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;  // branch target precomputed into ALUOut
      S_MEM_ADDR, S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_ADDI_WB: reg_write = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: directed scenarios plus randomized instruction streams,
// checked cycle by cycle against per-instruction state sequences and a per-state control table.
// Ports: drives clk, rst_n, opcode, mem_ready; observes every output.
module tb_multicycle_main_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic       illegal_op;
  logic [3:0] instr_count;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [3:0] m_cnt;
  logic       m_ill;

  multicycle_main_control #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return (op == 6'd0) || (op == 6'd35) || (op == 6'd43) ||
           (op == 6'd4) || (op == 6'd2) || (op == 6'd8);
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(0, 63));
  endfunction

  // Control word {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  //               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
  // taken straight from the per-state output table.
  function automatic logic [15:0] exp_ctrl(input int st, input logic mr);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iod = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      9:  begin pw = 1; psrc = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc};
  endfunction

  // One clock cycle: drive inputs after the falling edge, check before the next rising edge.
  task automatic step(input int exp_st, input logic mr, input logic [5:0] op);
    @(negedge clk);
    opcode    = op;
    mem_ready = mr;
    #1;
    chk("state", 32'(state), 32'(exp_st));
    chk("ctrl", 32'({pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                     pc_source}), 32'(exp_ctrl(exp_st, mr)));
    chk("illegal", 32'(illegal_op), 32'(m_ill));
    chk("count", 32'(instr_count), 32'(m_cnt));
  endtask

  // Runs one instruction from FETCH entry to the next FETCH entry.
  task automatic run_instr(input logic [5:0] op, input int fs, input int ms, output int cyc);
    int seq[$];
    cyc = 0;
    for (int i = 0; i <= fs; i++) begin
      step(0, (i == fs), rnd_op());
      cyc++;
    end
    step(1, 1'($urandom_range(0, 1)), op);
    cyc++;
    if (!is_legal(op)) begin
      m_ill = 1'b1;
      return;
    end
    case (op)
      6'd0:  seq = '{6, 7};
      6'd35: seq = '{2, 3, 4};
      6'd43: seq = '{2, 5};
      6'd4:  seq = '{8};
      6'd2:  seq = '{9};
      default: seq = '{10, 11};
    endcase
    foreach (seq[k]) begin
      if (seq[k] == 3 || seq[k] == 5) begin
        for (int j = 0; j <= ms; j++) begin
          step(seq[k], (j == ms), rnd_op());
          cyc++;
        end
      end else if (seq[k] == 2) begin
        step(seq[k], 1'($urandom_range(0, 1)), op);
        cyc++;
      end else begin
        step(seq[k], 1'($urandom_range(0, 1)), rnd_op());
        cyc++;
      end
    end
    m_cnt = m_cnt + 4'd1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [5:0] op;
    rst_n = 1'b0; opcode = 6'd0; mem_ready = 1'b1;
    m_cnt = 4'd0; m_ill = 1'b0;

    // Reset values with mem_ready high.
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctrl", 32'({pc_write, ir_write, mem_read, alu_src_b}), 32'b1_1_1_01);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    release_reset();

    // R-type, no stalls.
    run_instr(6'b000000, 0, 0, cyc);
    chk("rtype_cycles", 32'(cyc), 32'd4);
    step(0, 1'b0, rnd_op());
    chk("rtype_count", 32'(instr_count), 32'd1);

    // lw with 3 stall cycles in FETCH and in MEM_READ.
    run_instr(6'b100011, 3, 3, cyc);
    chk("lw_cycles", 32'(cyc), 32'd11);

    // beq then j.
    run_instr(6'b000100, 0, 0, cyc);
    chk("beq_cycles", 32'(cyc), 32'd3);
    run_instr(6'b000010, 0, 0, cyc);
    chk("j_cycles", 32'(cyc), 32'd3);
    step(0, 1'b0, rnd_op());
    chk("beq_j_count", 32'(instr_count), 32'd4);

    // Illegal opcode, then addi.
    run_instr(6'b111111, 0, 0, cyc);
    chk("illegal_cycles", 32'(cyc), 32'd2);
    run_instr(6'b001000, 0, 0, cyc);
    chk("addi_cycles", 32'(cyc), 32'd4);
    step(0, 1'b0, rnd_op());
    chk("illegal_sticky", 32'(illegal_op), 32'd1);
    chk("addi_count", 32'(instr_count), 32'd5);

    // Asynchronous reset in the middle of a stalled MEM_WRITE.
    step(0, 1'b1, rnd_op());
    step(1, 1'b0, 6'b101011);
    step(2, 1'b0, 6'b101011);
    step(5, 1'b0, rnd_op());
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_mem_write", 32'(mem_write), 32'd0);
    chk("async_count", 32'(instr_count), 32'd0);
    chk("async_illegal", 32'(illegal_op), 32'd0);
    m_cnt = 4'd0; m_ill = 1'b0;
    release_reset();

    // 17 jumps on a 4-bit counter wrap to 1.
    for (int n = 0; n < 17; n++) begin
      run_instr(6'b000010, 0, 0, cyc);
    end
    step(0, 1'b0, rnd_op());
    chk("wrap_count", 32'(instr_count), 32'd1);

    // Randomized instruction stream with random stalls.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 6))
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        4: op = 6'b000010;
        5: op = 6'b001000;
        default: begin
          op = rnd_op();
          while (is_legal(op)) op = rnd_op();
        end
      endcase
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), cyc);
    end
    step(0, 1'b0, rnd_op());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Moore-style main control FSM for the multicycle MIPS datapath.
- Decodes the IR opcode and sequences fetch/decode/execute/memory/writeback over 3–5 cycles per instruction.
- Drives every datapath select and enable, including the 2-bit alu_op consumed directly by the downstream ALU control decoder (together with IR[5:0]).
- Adds a memory-ready stall handshake, a sticky illegal-opcode flag and a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26], valid from DECODE onward
mem_ready  input  1  memory access completes this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero (beq)
i_or_d  output  1  0 = memory address from PC, 1 = from ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  load IR
mem_to_reg  output  1  0 = ALUOut, 1 = MDR to register write data
reg_dst  output  1  0 = rt, 1 = rd
reg_write  output  1  register file write enable
alu_src_a  output  1  0 = PC, 1 = A register
alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
alu_op  output  2  00 = add, 01 = subtract, 10 = use funct (to ALU control)
pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
state  output  4  current state encoding (debug)
illegal_op  output  1  sticky: unknown opcode decoded
instr_count  output  CNT_W  instructions retired

Behaviour:
- State encoding:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5
  - EXECUTE = 6, R_WB = 7, BRANCH = 8, JUMP = 9, ADDI_EX = 10, ADDI_WB = 11
  - Codes 12–15 unused; if ever reached, go to FETCH next cycle with all outputs at default.
- Reset (rst_n low, asynchronous): state = FETCH, illegal_op = 0, instr_count = 0. These take effect immediately, mid-instruction included, with no completion of the in-flight access.
- All control outputs decode from the state register only (plus mem_ready where noted). Any output not listed for a state is 0.
- FETCH:
  - mem_read = 1, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE:
  - alu_src_b = 11, alu_op = 00 (branch target into ALUOut).
  - Next state by opcode: 000000 → EXECUTE; 100011 or 101011 → MEM_ADDR; 000100 → BRANCH; 000010 → JUMP; 001000 → ADDI_EX.
  - Any other opcode → FETCH, illegal_op set to 1 and held until reset; instruction is not counted.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next state: MEM_READ if opcode = 100011, else MEM_WRITE.
- MEM_READ: mem_read = 1, i_or_d = 1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WRITE:
  - mem_write = 1, i_or_d = 1.
  - Holds until mem_ready, then goes to FETCH and retires.
  - mem_write stays asserted throughout the hold.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Next state FETCH; retires.
- EXECUTE: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Next state R_WB.
- R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Next state FETCH; retires.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01. Next state FETCH; retires.
- JUMP: pc_write = 1, pc_source = 10. Next state FETCH; retires.
- ADDI_EX: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next state ADDI_WB.
- ADDI_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Next state FETCH; retires.
- instr_count:
  - Increments by 1 on the clock edge leaving a retiring state (MEM_WRITE only when mem_ready = 1).
  - Wraps modulo 2^CNT_W with no flag.
- opcode is sampled only in DECODE and MEM_ADDR. Changes in other states have no effect.
- Latency with mem_ready tied 1 (cycles from FETCH entry to next FETCH entry): R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.

Test Plan:
- Reset with mem_ready = 1; release; run opcode 000000 → state sequence 0,1,6,7,0; alu_op = 10 in EXECUTE; reg_write = 1 with reg_dst = 1 in R_WB; instr_count = 1.
- lw (100011) with mem_ready low for 3 cycles in both FETCH and MEM_READ → FETCH and MEM_READ each held 4 cycles; ir_write pulses once, in the final FETCH cycle only; MEM_WB asserts mem_to_reg = 1; total 11 cycles; instr_count = 1.
- beq (000100) then j (000010) → BRANCH outputs alu_op = 01, pc_write_cond = 1, pc_source = 01; JUMP outputs pc_write = 1, pc_source = 10; each takes 3 cycles; instr_count = 2.
- Opcode 111111 at DECODE → next state FETCH; illegal_op = 1 and stays 1 through a following addi (001000); instr_count unchanged by the illegal op, +1 for the addi.
- Assert rst_n low mid-MEM_WRITE while mem_ready = 0 → state = 0 and mem_write = 0 immediately (asynchronous); instr_count = 0; illegal_op = 0.
- With CNT_W = 4, retire 17 j instructions → instr_count wraps to 1.
